// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Samples the serial line at mid-bit and
//               recovers one byte per frame, LSB first. Each recovered byte
//               is presented with a one-cycle done strobe, and frames whose
//               stop bit reads 0 are flagged.
// Ports       :
//   clock        in   1  system clock, rising edge
//   reset        in   1  synchronous, active-high reset
//   rx           in   1  asynchronous serial input, idles high
//   readdata     out  8  last received byte
//   done         out  1  one-cycle pulse, readdata/frame_error valid from it
//   active       out  1  high while a frame is in progress (START..STOP)
//   frame_error  out  1  stop bit of the last frame sampled 0
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int unsigned uart_clock_bit = 5208  // clock cycles per bit, >= 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] readdata,
  output logic       done,
  output logic       active,
  output logic       frame_error
);

  localparam int unsigned HALF  = uart_clock_bit / 2;
  localparam int unsigned CNT_W = $clog2(uart_clock_bit);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [1:0]       flush;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             start_edge;
  logic             half_tick;
  logic             bit_tick;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // The synchronizer comes out of reset holding 1s, so a line that is low at
  // reset release would look like a falling edge. flush marks when rx_s holds
  // a genuine line sample; armed is only set once that genuine sample is high,
  // so a start edge requires the line to have really been seen idle first.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush <= 2'b00;
      armed <= 1'b0;
    end else begin
      flush <= {flush[0], 1'b1};
      armed <= armed | (flush[1] & rx_s);
    end
  end

  assign start_edge = armed & rx_prev & ~rx_s;
  assign half_tick  = (cnt == CNT_W'(HALF - 1));
  assign bit_tick   = (cnt == CNT_W'(uart_clock_bit - 1));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_edge) state_next = S_START;
      end
      S_START: begin
        // A line back high at mid start bit was a glitch.
        if (half_tick) state_next = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_tick && (bit_idx == 3'd7)) state_next = S_STOP;
      end
      S_STOP: begin
        // Leaving at mid stop bit lets a start bit right after it be caught.
        if (bit_tick) state_next = rx_s ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    active = 1'b0;
    case (state)
      S_START, S_DATA, S_STOP: active = 1'b1;
      default:                 active = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Bit timing and data path
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      case (state)
        S_START: begin
          cnt     <= half_tick ? '0 : cnt + 1'b1;
          bit_idx <= 3'd0;
        end
        S_DATA: begin
          cnt <= bit_tick ? '0 : cnt + 1'b1;
          if (bit_tick) begin
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
          end
        end
        S_STOP: begin
          cnt <= bit_tick ? '0 : cnt + 1'b1;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Results are registered off the stop-bit sample, so they appear together
  // with done one cycle after that sample and then hold until the next frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      done        <= 1'b0;
      readdata    <= 8'h00;
      frame_error <= 1'b0;
    end else begin
      done <= (state == S_STOP) && bit_tick;
      if ((state == S_STOP) && bit_tick) begin
        readdata    <= shift;
        frame_error <= ~rx_s;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx with 16-cycle bits.
//               rx is driven on the falling clock edge and outputs are
//               observed on the falling edge, away from the active edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int unsigned BIT = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] readdata;
  logic       done;
  logic       active;
  logic       frame_error;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // monitor state
  int unsigned cyc         = 0;
  int unsigned done_cnt    = 0;
  int unsigned done_cyc    = 0;
  int unsigned double_cnt  = 0;
  logic        prev_done   = 1'b0;
  logic [7:0]  got_bytes[$];

  uart_rx #(.uart_clock_bit(BIT)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .readdata    (readdata),
    .done        (done),
    .active      (active),
    .frame_error (frame_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      got_bytes.push_back(readdata);
      if (prev_done) double_cnt = double_cnt + 1;
    end
    prev_done = done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_cycles(BIT);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  int unsigned base_cnt;
  int unsigned start_cyc;
  logic [7:0]  b2b [5] = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAF};

  initial begin
    // ---------------- reset and idle ----------------
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(100);
    check("idle_done_cnt", done_cnt, 0);
    check("idle_active", active, 1'b0);
    check("idle_frame_error", frame_error, 1'b0);
    check("idle_readdata", readdata, 8'h00);

    // ---------------- reset during bit 4 of 0xF0 ----------------
    // start bit plus bits 0..3 are all low
    rx = 1'b0;
    wait_cycles(5 * BIT);
    rx = 1'b1;                    // bit 4
    wait_cycles(BIT / 2);
    check("f0_active_mid", active, 1'b1);
    reset = 1'b1;
    wait_cycles(1);
    check("f0_active_after_reset", active, 1'b0);
    reset = 1'b0;
    wait_cycles(BIT / 2 + 3 * BIT + BIT + 40);  // rest of bit 4, bits 5..7, stop
    check("f0_no_done", done_cnt, 0);
    check("f0_readdata_kept", readdata, 8'h00);

    // ---------------- single frame 0x55 with latency ----------------
    base_cnt  = done_cnt;
    start_cyc = cyc + 1;          // posedge that captures the falling edge
    send_frame(8'h55, 1'b1);
    wait_cycles(30);
    check("f55_done_cnt", done_cnt - base_cnt, 1);
    check("f55_readdata", readdata, 8'h55);
    check("f55_frame_error", frame_error, 1'b0);
    check("f55_latency", done_cyc, start_cyc + 3 + 8 + 144 - 1);

    // ---------------- back-to-back frames ----------------
    base_cnt = done_cnt;
    got_bytes.delete();
    for (int i = 0; i < 5; i++) send_frame(b2b[i], 1'b1);
    wait_cycles(40);
    check("b2b_done_cnt", done_cnt - base_cnt, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_bytes.size()) check($sformatf("b2b_byte%0d", i), got_bytes[i], b2b[i]);
      else                      check($sformatf("b2b_byte%0d", i), 32'hDEAD, b2b[i]);
    end
    check("b2b_no_merged_done", double_cnt, 0);
    check("b2b_frame_error", frame_error, 1'b0);

    // ---------------- 4-cycle low glitch ----------------
    base_cnt = done_cnt;
    rx = 1'b0;
    wait_cycles(4);
    check("glitch_active_high", active, 1'b1);
    rx = 1'b1;
    wait_cycles(8);
    check("glitch_active_low", active, 1'b0);
    wait_cycles(200);
    check("glitch_no_done", done_cnt - base_cnt, 0);
    check("glitch_readdata_kept", readdata, 8'hAF);

    // ---------------- 0x3C with low stop, then break ----------------
    base_cnt = done_cnt;
    send_frame(8'h3C, 1'b0);
    wait_cycles(40);              // line still low: break
    check("f3c_done_cnt", done_cnt - base_cnt, 1);
    check("f3c_readdata", readdata, 8'h3C);
    check("f3c_frame_error", frame_error, 1'b1);
    check("f3c_break_active", active, 1'b0);
    rx = 1'b1;
    wait_cycles(20);
    check("break_no_new_frame", done_cnt - base_cnt, 1);
    send_frame(8'h01, 1'b1);
    wait_cycles(30);
    check("f01_done_cnt", done_cnt - base_cnt, 2);
    check("f01_readdata", readdata, 8'h01);
    check("f01_frame_error", frame_error, 1'b0);
    check("final_no_merged_done", double_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
